// File: rtl/trigger_conditioner.sv
//==============================================================================
// Module      : trigger_conditioner
// Description : Input conditioner for a delay-timer trigger contact.
//               Synchronises a raw asynchronous contact, optionally inverts
//               it, samples it on a prescaled tick and commits a level change
//               only after db_len consecutive agreeing samples. Provides
//               rise/fall pulses, a pending flag and a saturating count of
//               rejected glitches.
// Ports       :
//   clk        in   1      system clock (rising edge)
//   reset      in   1      asynchronous active-high reset, sync release
//   trig_raw   in   1      raw trigger contact, asynchronous to clk
//   invert     in   1      1: contact is active-low
//   db_len     in   CNT_W  consecutive agreeing samples needed (0 acts as 1)
//   trigger    out  1      debounced trigger level
//   trig_rise  out  1      1-clk pulse when trigger becomes 1
//   trig_fall  out  1      1-clk pulse when trigger becomes 0
//   busy       out  1      candidate change pending
//   glitch_cnt out  8      rejected candidate changes, saturating at 255
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module trigger_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig_raw,
    input  logic             invert,
    input  logic [CNT_W-1:0] db_len,
    output logic             trigger,
    output logic             trig_rise,
    output logic             trig_fall,
    output logic             busy,
    output logic [7:0]       glitch_cnt
);

    localparam int                c_PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [CNT_W-1:0]       r_cnt;
    logic [7:0]             r_glitch_cnt;
    logic                   r_trigger;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;
    state_t                 r_state;

    logic                   w_tick;
    logic                   w_s;
    logic [CNT_W-1:0]       w_eff_len;
    logic [CNT_W-1:0]       w_cnt_inc;

    //--------------------------------------------------------------------------
    // Synchroniser: bit 0 is the metastability-exposed stage.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], trig_raw};
        end
    end

    //--------------------------------------------------------------------------
    // Free-running sample prescaler.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end

    assign w_tick    = (r_presc == c_PRESC_MAX);
    // Inversion is applied after synchronisation, so an invert change is
    // debounced exactly like a contact change.
    assign w_s       = r_sync[SYNC_STAGES-1] ^ invert;
    assign w_eff_len = (db_len == '0) ? c_CNT_ONE : db_len;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + c_CNT_ONE);

    //--------------------------------------------------------------------------
    // Debounce FSM. Only advances on tick; edge pulses default low every clk
    // so they last exactly one cycle.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_STABLE;
            r_cnt        <= '0;
            r_trigger    <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_busy       <= 1'b0;
            r_glitch_cnt <= 8'd0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_STABLE: begin
                        if (w_s != r_trigger) begin
                            if (w_eff_len == c_CNT_ONE) begin
                                r_trigger <= w_s;
                                r_rise    <= w_s;
                                r_fall    <= ~w_s;
                                r_cnt     <= '0;
                            end else begin
                                r_cnt   <= c_CNT_ONE;
                                r_state <= ST_PEND;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    ST_PEND: begin
                        if (w_s == r_trigger) begin
                            // Input bounced back before qualifying.
                            if (r_glitch_cnt != 8'hFF) begin
                                r_glitch_cnt <= r_glitch_cnt + 8'd1;
                            end
                            r_cnt   <= '0;
                            r_state <= ST_STABLE;
                            r_busy  <= 1'b0;
                        end else if (w_cnt_inc >= w_eff_len) begin
                            // >= so a live reduction of db_len commits at once.
                            r_trigger <= w_s;
                            r_rise    <= w_s;
                            r_fall    <= ~w_s;
                            r_cnt     <= '0;
                            r_state   <= ST_STABLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= ST_STABLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign trigger    = r_trigger;
    assign trig_rise  = r_rise;
    assign trig_fall  = r_fall;
    assign busy       = r_busy;
    assign glitch_cnt = r_glitch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trigger_conditioner.sv
//==============================================================================
// Module      : tb_trigger_conditioner
// Description : Self-checking bench for trigger_conditioner. Expected edge
//               pulses (type and arrival window) are queued when stimulus is
//               driven and matched by a monitor when the DUT pulses.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_trigger_conditioner;

    localparam int c_PRESCALE = 4;
    localparam int c_SYNC     = 2;
    localparam int c_CNT_W    = 8;

    logic               clk;
    logic               reset;
    logic               trig_raw;
    logic               invert;
    logic [c_CNT_W-1:0] db_len;
    logic               trigger;
    logic               trig_rise;
    logic               trig_fall;
    logic               busy;
    logic [7:0]         glitch_cnt;

    typedef struct {
        bit rise;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks;
    int   errors;
    int   cyc;
    int   rel_cyc;

    trigger_conditioner #(
        .SYNC_STAGES(c_SYNC),
        .PRESCALE   (c_PRESCALE),
        .CNT_W      (c_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trig_raw  (trig_raw),
        .invert    (invert),
        .db_len    (db_len),
        .trigger   (trigger),
        .trig_rise (trig_rise),
        .trig_fall (trig_fall),
        .busy      (busy),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard monitor: every edge pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && (trig_rise || trig_fall)) begin
            checks = checks + 1;
            if (trig_rise && trig_fall) begin
                errors = errors + 1;
                $display("FAIL both_pulses rise=%0b fall=%0b cyc=%0d", trig_rise, trig_fall, cyc);
            end else if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse rise=%0b fall=%0b cyc=%0d", trig_rise, trig_fall, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_e.rise != trig_rise) || (cyc < mon_e.lo) || (cyc > mon_e.hi) ||
                    (trigger !== trig_rise)) begin
                    errors = errors + 1;
                    $display("FAIL pulse_match got rise=%0b trigger=%0b cyc=%0d expected rise=%0b window=%0d..%0d",
                             trig_rise, trigger, cyc, mon_e.rise, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input bit r, input int lo, input int hi);
        exp_t e;
        e.rise = r;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        trig_raw = 1'b0;
        invert   = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic check_queue_empty(input string name);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s missing_pulses outstanding=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // 1: held in reset with a toggling contact, everything stays 0.
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (i % 3 == 0) trig_raw = ~trig_raw;
            @(negedge clk);
            checks = checks + 1;
            if ({trigger, trig_rise, trig_fall, busy, glitch_cnt} !== 12'd0) begin
                errors = errors + 1;
                $display("FAIL reset_outputs trig=%0b rise=%0b fall=%0b busy=%0b glitch=%0d required all 0",
                         trigger, trig_rise, trig_fall, busy, glitch_cnt);
            end
        end
    endtask

    // 2: clean rise and fall with db_len=3.
    task automatic test_rise_fall();
        int  t0;
        int  nb;
        bit  seen;
        do_reset();
        db_len = 8'd3;
        wait_clks(10);
        for (int ph = 0; ph < 2; ph++) begin
            bit v;
            v  = (ph == 0);
            trig_raw = v;
            t0 = cyc;
            push_exp(v, t0 + 11, t0 + 15);
            nb   = 0;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (trigger === v) seen = 1'b1;
                else if (busy === 1'b1) nb++;
            end
            checks = checks + 1;
            if (!seen || nb != 8) begin
                errors = errors + 1;
                $display("FAIL rise_fall_busy ph=%0d seen=%0b busy_clks=%0d required seen=1 busy_clks=8", ph, seen, nb);
            end
            wait_clks(40 - 20);
            checks = checks + 1;
            if (trigger !== v || busy !== 1'b0 || glitch_cnt !== 8'd0) begin
                errors = errors + 1;
                $display("FAIL rise_fall_settled ph=%0d trig=%0b busy=%0b glitch=%0d required trig=%0b busy=0 glitch=0",
                         ph, trigger, busy, glitch_cnt, v);
            end
            check_queue_empty("rise_fall");
        end
    endtask

    // 3: short pulse rejected and counted.
    task automatic test_glitch();
        do_reset();
        db_len = 8'd3;
        wait_clks(8);
        trig_raw = 1'b1;
        wait_clks(5);
        trig_raw = 1'b0;
        wait_clks(20);
        checks = checks + 1;
        if (trigger !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 8'd1) begin
            errors = errors + 1;
            $display("FAIL glitch trig=%0b busy=%0b glitch=%0d required trig=0 busy=0 glitch=1",
                     trigger, busy, glitch_cnt);
        end
        check_queue_empty("glitch");
    endtask

    // 4: db_len=0 behaves as 1, no PEND.
    task automatic test_db_len_zero();
        int t0;
        int nb;
        do_reset();
        db_len = 8'd0;
        wait_clks(8);
        trig_raw = 1'b1;
        t0 = cyc;
        push_exp(1'b1, t0 + 3, t0 + 7);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
        end
        checks = checks + 1;
        if (trigger !== 1'b1 || nb != 0) begin
            errors = errors + 1;
            $display("FAIL db_len_zero trig=%0b busy_clks=%0d required trig=1 busy_clks=0", trigger, nb);
        end
        wait_clks(4);
        check_queue_empty("db_len_zero");
    endtask

    // 5: tick-aligned bursts, one glitch each, saturating at 255.
    task automatic test_glitch_saturate();
        do_reset();
        db_len = 8'd4;
        do begin
            @(posedge clk);
            #1;
        end while (((cyc - rel_cyc) % c_PRESCALE) != 1);
        for (int b = 0; b < 300; b++) begin
            trig_raw = 1'b1;
            wait_clks(2);
            trig_raw = 1'b0;
            wait_clks(10);
            if (b == 99) begin
                checks = checks + 1;
                if (glitch_cnt !== 8'd100) begin
                    errors = errors + 1;
                    $display("FAIL glitch_count_100 glitch=%0d required 100", glitch_cnt);
                end
            end
        end
        wait_clks(10);
        checks = checks + 1;
        if (trigger !== 1'b0 || glitch_cnt !== 8'd255) begin
            errors = errors + 1;
            $display("FAIL glitch_saturate trig=%0b glitch=%0d required trig=0 glitch=255", trigger, glitch_cnt);
        end
        check_queue_empty("glitch_saturate");
    endtask

    // 6: inverted idle contact, reset during PEND, restart after release.
    task automatic test_invert_reset();
        bit seen;
        reset    = 1'b1;
        trig_raw = 1'b0;
        invert   = 1'b1;
        db_len   = 8'd3;
        exp_q.delete();
        wait_clks(2);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        checks = checks + 1;
        if (!seen || trigger !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL invert_pend busy_seen=%0b trig=%0b required busy_seen=1 trig=0", seen, trigger);
        end
        #100;
        reset = 1'b1;
        #1;
        checks = checks + 1;
        if ({trigger, trig_rise, trig_fall, busy, glitch_cnt} !== 12'd0) begin
            errors = errors + 1;
            $display("FAIL reset_mid_pend trig=%0b rise=%0b fall=%0b busy=%0b glitch=%0d required all 0",
                     trigger, trig_rise, trig_fall, busy, glitch_cnt);
        end
        wait_clks(2);
        reset   = 1'b0;
        rel_cyc = cyc;
        push_exp(1'b1, rel_cyc + 11, rel_cyc + 15);
        wait_clks(20);
        checks = checks + 1;
        if (trigger !== 1'b1 || glitch_cnt !== 8'd0 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL invert_restart trig=%0b glitch=%0d busy=%0b required trig=1 glitch=0 busy=0",
                     trigger, glitch_cnt, busy);
        end
        check_queue_empty("invert_reset");
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rel_cyc  = 0;
        reset    = 1'b1;
        trig_raw = 1'b0;
        invert   = 1'b0;
        db_len   = 8'd3;
        test_reset();
        test_rise_fall();
        test_glitch();
        test_db_len_zero();
        test_glitch_saturate();
        test_invert_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
